// File: rtl/burst_xfer_engine.sv
// burst_xfer_engine: moves a programmed number of beats between the register
// bank and a valid/ready burst interface. Write mode streams register-bank
// words out as bursts. Read mode stores incoming bursts into the register bank.
// Beats are framed with a last marker every max_burst_size beats and on the
// final beat. Register-bank addresses wrap modulo 2^ADDR_W.
// Optional feature: define BURST_LAST_CHECK_EN to check incoming burst_last
// framing in read mode and flag mismatches on the sticky db_rb_err output.
module burst_xfer_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rb_db_start,
  input  logic              rb_db_rw,
  input  logic [LEN_W-1:0]  rb_db_length,
  input  logic [LEN_W-1:0]  rb_db_max_burst_size,
  input  logic [ADDR_W-1:0] rb_db_base_addr,
  input  logic              rb_db_ack,
  input  logic [DATA_W-1:0] rb_db_data,
  output logic              db_rb_req,
  output logic              db_rb_we,
  output logic [ADDR_W-1:0] db_rb_addr,
  output logic [DATA_W-1:0] db_rb_data,
  output logic              db_rb_idle,
  output logic              db_rb_done,
  output logic              db_rb_err,
  output logic [LEN_W-1:0]  db_length,
  output logic              db_valid,
  output logic [DATA_W-1:0] data_burst_out,
  output logic              last,
  input  logic              burst_ready,
  input  logic              burst_valid,
  input  logic [DATA_W-1:0] data_burst_in,
  input  logic              burst_last,
  output logic              db_ready
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_WR_REQ   = 3'd2;
  localparam logic [2:0] S_WR_SEND  = 3'd3;
  localparam logic [2:0] S_RD_RECV  = 3'd4;
  localparam logic [2:0] S_RD_STORE = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]       state;
  logic [LEN_W-1:0] beat_rem;
  logic [LEN_W-1:0] burst_rem;
  logic [LEN_W-1:0] burst_size;
  logic             beat_acc;
  logic             exp_last;
  logic             final_beat;

  // A beat completes when the sink takes it (write) or the bank stores it (read).
  assign beat_acc   = ((state == S_WR_SEND) && burst_ready) ||
                      ((state == S_RD_STORE) && rb_db_ack);
  assign final_beat = (beat_rem == LEN_W'(1));
  assign exp_last   = final_beat || (burst_rem == LEN_W'(1));

  // Outputs decoded purely from registered state and counters.
  assign db_rb_req  = (state == S_WR_REQ) || (state == S_RD_STORE);
  assign db_rb_we   = (state == S_RD_STORE);
  assign db_rb_idle = (state == S_IDLE);
  assign db_rb_done = (state == S_DONE);
  assign db_valid   = (state == S_WR_SEND);
  assign db_ready   = (state == S_RD_RECV);
  assign last       = (state == S_WR_SEND) && exp_last;

  // Transaction sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:     if (rb_db_start) state <= S_LOAD;
        S_LOAD: begin
          if (rb_db_length == '0) state <= S_DONE;
          else if (rb_db_rw)      state <= S_WR_REQ;
          else                    state <= S_RD_RECV;
        end
        S_WR_REQ:   if (rb_db_ack) state <= S_WR_SEND;
        S_WR_SEND:  if (burst_ready) state <= final_beat ? S_DONE : S_WR_REQ;
        S_RD_RECV:  if (burst_valid) state <= S_RD_STORE;
        S_RD_STORE: if (rb_db_ack) state <= final_beat ? S_DONE : S_RD_RECV;
        S_DONE:     state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

  // Parameter capture in LOAD, then beat/burst counters and address advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_length  <= '0;
      beat_rem   <= '0;
      burst_rem  <= '0;
      burst_size <= '0;
      db_rb_addr <= '0;
    end else if (state == S_LOAD) begin
      db_length  <= rb_db_length;
      beat_rem   <= rb_db_length;
      burst_size <= (rb_db_max_burst_size == '0) ? LEN_W'(1) : rb_db_max_burst_size;
      burst_rem  <= (rb_db_max_burst_size == '0) ? LEN_W'(1) : rb_db_max_burst_size;
      db_rb_addr <= rb_db_base_addr;
    end else if (beat_acc) begin
      beat_rem   <= beat_rem - LEN_W'(1);
      db_rb_addr <= db_rb_addr + ADDR_W'(1);
      burst_rem  <= (burst_rem == LEN_W'(1)) ? burst_size : burst_rem - LEN_W'(1);
    end
  end

  // Beat data capture: bank word on ack (write), incoming beat on valid (read).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_burst_out <= '0;
      db_rb_data     <= '0;
    end else begin
      if ((state == S_WR_REQ) && rb_db_ack)   data_burst_out <= rb_db_data;
      if ((state == S_RD_RECV) && burst_valid) db_rb_data    <= data_burst_in;
    end
  end

`ifdef BURST_LAST_CHECK_EN
  // Sticky framing error: incoming last marker disagrees with the expected one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_rb_err <= 1'b0;
    end else if (state == S_LOAD) begin
      db_rb_err <= 1'b0;
    end else if ((state == S_RD_RECV) && burst_valid && (burst_last != exp_last)) begin
      db_rb_err <= 1'b1;
    end
  end
`else
  logic unused_burst_last;
  assign unused_burst_last = burst_last;
  assign db_rb_err         = 1'b0;
`endif

endmodule

// File: tb/tb_burst_xfer_engine.sv
// Directed bench for burst_xfer_engine: table of transactions with
// hand-computed beat addresses/data/last markers, plus hand sequences for
// length-0, back-pressure stall and reset-during-transfer.
`timescale 1ns/1ps
module tb_burst_xfer_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rb_db_start;
  logic       rb_db_rw;
  logic [7:0] rb_db_length;
  logic [7:0] rb_db_max_burst_size;
  logic [8:0] rb_db_base_addr;
  logic       rb_db_ack;
  logic [7:0] rb_db_data;
  logic       db_rb_req;
  logic       db_rb_we;
  logic [8:0] db_rb_addr;
  logic [7:0] db_rb_data;
  logic       db_rb_idle;
  logic       db_rb_done;
  logic       db_rb_err;
  logic [7:0] db_length;
  logic       db_valid;
  logic [7:0] data_burst_out;
  logic       last;
  logic       burst_ready;
  logic       burst_valid;
  logic [7:0] data_burst_in;
  logic       burst_last;
  logic       db_ready;
  logic       ack_en;

  burst_xfer_engine dut (
    .clk(clk), .rst_n(rst_n),
    .rb_db_start(rb_db_start), .rb_db_rw(rb_db_rw),
    .rb_db_length(rb_db_length), .rb_db_max_burst_size(rb_db_max_burst_size),
    .rb_db_base_addr(rb_db_base_addr), .rb_db_ack(rb_db_ack), .rb_db_data(rb_db_data),
    .db_rb_req(db_rb_req), .db_rb_we(db_rb_we), .db_rb_addr(db_rb_addr),
    .db_rb_data(db_rb_data), .db_rb_idle(db_rb_idle), .db_rb_done(db_rb_done),
    .db_rb_err(db_rb_err), .db_length(db_length),
    .db_valid(db_valid), .data_burst_out(data_burst_out), .last(last),
    .burst_ready(burst_ready), .burst_valid(burst_valid),
    .data_burst_in(data_burst_in), .burst_last(burst_last), .db_ready(db_ready)
  );

  always #5 clk = ~clk;

  // Register bank model: zero-wait ack, word = low address byte ^ 0x5A.
  assign rb_db_ack  = ack_en & db_rb_req;
  assign rb_db_data = db_rb_addr[7:0] ^ 8'h5A;

`ifdef BURST_LAST_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  typedef struct packed {
    logic [8:0] a;
    logic [7:0] d;
    logic       l;
  } rec_t;

  typedef struct {
    logic            rw;
    logic [8:0]      base;
    logic [7:0]      len;
    logic [7:0]      mb;
    logic [4:0][7:0] din;
    logic [4:0]      lin;
    int              n;
    logic [4:0][8:0] eaddr;
    logic [4:0][7:0] edata;
    logic [4:0]      elast;
    logic            eerr;
  } vec_t;

  rec_t obq[$];
  rec_t rbq[$];
  int   req_cycles, valid_cycles, done_cnt;
  int   n_chk = 0;
  int   n_fail = 0;

  // Observe accepted outgoing beats, bank writes and pulse counts.
  always @(negedge clk) begin
    if (db_rb_req)  req_cycles++;
    if (db_valid)   valid_cycles++;
    if (db_rb_done) done_cnt++;
    if (db_valid && burst_ready) obq.push_back('{db_rb_addr, data_burst_out, last});
    if (db_rb_req && db_rb_we && rb_db_ack) rbq.push_back('{db_rb_addr, db_rb_data, 1'b0});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_obs();
    obq.delete();
    rbq.delete();
    req_cycles = 0;
    valid_cycles = 0;
    done_cnt = 0;
  endtask

  // Pulse start for one edge, then scramble the config once LOAD has latched it.
  task automatic start_xfer(input logic rw, input logic [8:0] base,
                            input logic [7:0] len, input logic [7:0] mb);
    @(posedge clk); #1;
    rb_db_rw = rw;
    rb_db_base_addr = base;
    rb_db_length = len;
    rb_db_max_burst_size = mb;
    rb_db_start = 1'b1;
    @(posedge clk); #1;
    rb_db_start = 1'b0;
    @(posedge clk); #1;
    rb_db_rw = ~rw;
    rb_db_base_addr = base ^ 9'h0AA;
    rb_db_length = 8'hFF;
    rb_db_max_burst_size = 8'h07;
  endtask

  task automatic rd_send(input string tag, input logic [7:0] d, input logic l);
    logic ok;
    ok = 1'b0;
    burst_valid = 1'b1;
    data_burst_in = d;
    burst_last = l;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (db_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    burst_valid = 1'b0;
    chk({tag, "_accept"}, ok, 1);
  endtask

  task automatic wait_done(input string tag);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (db_rb_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, ok, 1);
    @(posedge clk); #1;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{rw:1'b1, base:9'h010, len:8'd5, mb:8'd2,
                din:{8'h00,8'h00,8'h00,8'h00,8'h00}, lin:5'b00000, n:5,
                eaddr:{9'h014,9'h013,9'h012,9'h011,9'h010},
                edata:{8'h4E,8'h49,8'h48,8'h4B,8'h4A}, elast:5'b11010, eerr:1'b0};
    vecs[1] = '{rw:1'b0, base:9'h1FE, len:8'd4, mb:8'd4,
                din:{8'h00,8'h44,8'h33,8'h22,8'h11}, lin:5'b01000, n:4,
                eaddr:{9'h000,9'h001,9'h000,9'h1FF,9'h1FE},
                edata:{8'h00,8'h44,8'h33,8'h22,8'h11}, elast:5'b00000, eerr:1'b0};
    vecs[2] = '{rw:1'b0, base:9'h020, len:8'd4, mb:8'd2,
                din:{8'h00,8'hC4,8'hC3,8'hC2,8'hC1}, lin:5'b01000, n:4,
                eaddr:{9'h000,9'h023,9'h022,9'h021,9'h020},
                edata:{8'h00,8'hC4,8'hC3,8'hC2,8'hC1}, elast:5'b00000, eerr:ERR_EXP};
    vecs[3] = '{rw:1'b1, base:9'h1FF, len:8'd3, mb:8'd0,
                din:{8'h00,8'h00,8'h00,8'h00,8'h00}, lin:5'b00000, n:3,
                eaddr:{9'h000,9'h000,9'h001,9'h000,9'h1FF},
                edata:{8'h00,8'h00,8'h5B,8'h5A,8'hA5}, elast:5'b00111, eerr:1'b0};
    vecs[4] = '{rw:1'b0, base:9'h100, len:8'd3, mb:8'd2,
                din:{8'h00,8'h00,8'h03,8'h02,8'h01}, lin:5'b00110, n:3,
                eaddr:{9'h000,9'h000,9'h102,9'h101,9'h100},
                edata:{8'h00,8'h00,8'h03,8'h02,8'h01}, elast:5'b00000, eerr:1'b0};

    rst_n = 1'b0;
    rb_db_start = 1'b0;
    rb_db_rw = 1'b0;
    rb_db_length = '0;
    rb_db_max_burst_size = '0;
    rb_db_base_addr = '0;
    burst_ready = 1'b1;
    burst_valid = 1'b0;
    data_burst_in = '0;
    burst_last = 1'b0;
    ack_en = 1'b1;
    clear_obs();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_idle", db_rb_idle, 1);
    chk("rst_ctrl", {db_rb_req, db_rb_we, db_rb_done, db_rb_err, db_valid, last, db_ready}, 0);
    chk("rst_data", {db_rb_addr, db_rb_data, db_length, data_burst_out}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      clear_obs();
      start_xfer(vecs[i].rw, vecs[i].base, vecs[i].len, vecs[i].mb);
      if (!vecs[i].rw)
        for (int j = 0; j < vecs[i].n; j++)
          rd_send($sformatf("v%0d_b%0d", i, j), vecs[i].din[j], vecs[i].lin[j]);
      wait_done($sformatf("v%0d", i));
      chk($sformatf("v%0d_idle_after", i), db_rb_idle, 1);
      chk($sformatf("v%0d_done_cnt", i), done_cnt, 1);
      chk($sformatf("v%0d_err", i), db_rb_err, vecs[i].eerr);
      chk($sformatf("v%0d_length", i), db_length, vecs[i].len);
      if (vecs[i].rw) begin
        chk($sformatf("v%0d_nbeats", i), obq.size(), vecs[i].n);
        for (int j = 0; j < vecs[i].n && j < obq.size(); j++) begin
          chk($sformatf("v%0d_b%0d_addr", i, j), obq[j].a, vecs[i].eaddr[j]);
          chk($sformatf("v%0d_b%0d_data", i, j), obq[j].d, vecs[i].edata[j]);
          chk($sformatf("v%0d_b%0d_last", i, j), obq[j].l, vecs[i].elast[j]);
        end
      end else begin
        chk($sformatf("v%0d_nwrites", i), rbq.size(), vecs[i].n);
        for (int j = 0; j < vecs[i].n && j < rbq.size(); j++) begin
          chk($sformatf("v%0d_w%0d_addr", i, j), rbq[j].a, vecs[i].eaddr[j]);
          chk($sformatf("v%0d_w%0d_data", i, j), rbq[j].d, vecs[i].edata[j]);
        end
      end
    end

    // Length 0 with max_burst 0: done two cycles after start, no traffic.
    clear_obs();
    @(posedge clk); #1;
    rb_db_rw = 1'b1;
    rb_db_base_addr = 9'h055;
    rb_db_length = 8'd0;
    rb_db_max_burst_size = 8'd0;
    rb_db_start = 1'b1;
    @(posedge clk); #1;
    rb_db_start = 1'b0;
    @(posedge clk); #1;
    chk("len0_done_n2", db_rb_done, 1);
    chk("len0_idle_n2", db_rb_idle, 0);
    @(posedge clk); #1;
    chk("len0_done_n3", db_rb_done, 0);
    chk("len0_idle_n3", db_rb_idle, 1);
    chk("len0_req_cycles", req_cycles, 0);
    chk("len0_valid_cycles", valid_cycles, 0);
    chk("len0_done_cnt", done_cnt, 1);
    chk("len0_length", db_length, 0);

    // Back-pressure on beat 2: beat held stable, nothing lost or duplicated.
    begin
      logic ok;
      logic [7:0] exp_d [3];
      logic       exp_l [3];
      exp_d[0] = 8'h6A; exp_d[1] = 8'h6B; exp_d[2] = 8'h68;
      exp_l[0] = 1'b0;  exp_l[1] = 1'b0;  exp_l[2] = 1'b1;
      clear_obs();
      start_xfer(1'b1, 9'h030, 8'd3, 8'd3);
      chk("stall_first_req", db_rb_req, 1);
      chk("stall_idle_low", db_rb_idle, 0);
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (db_valid && burst_ready) begin
          ok = 1'b1;
          break;
        end
      end
      chk("stall_beat1_seen", ok, 1);
      @(posedge clk); #1;
      burst_ready = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (db_valid) begin
          ok = 1'b1;
          break;
        end
      end
      chk("stall_beat2_valid", ok, 1);
      for (int k = 0; k < 3; k++) begin
        if (k > 0) @(negedge clk);
        chk($sformatf("stall_c%0d_valid", k), db_valid, 1);
        chk($sformatf("stall_c%0d_data", k), data_burst_out, 8'h6B);
        chk($sformatf("stall_c%0d_last", k), last, 0);
      end
      @(posedge clk); #1;
      burst_ready = 1'b1;
      wait_done("stall");
      chk("stall_nbeats", obq.size(), 3);
      for (int j = 0; j < 3 && j < obq.size(); j++) begin
        chk($sformatf("stall_b%0d_addr", j), obq[j].a, 9'h030 + 9'(j));
        chk($sformatf("stall_b%0d_data", j), obq[j].d, exp_d[j]);
        chk($sformatf("stall_b%0d_last", j), obq[j].l, exp_l[j]);
      end
    end

    // Reset while a beat is waiting in WR_SEND, then a clean transfer.
    begin
      logic ok;
      clear_obs();
      burst_ready = 1'b0;
      start_xfer(1'b1, 9'h040, 8'd4, 8'd4);
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (db_valid) begin
          ok = 1'b1;
          break;
        end
      end
      chk("rstmid_in_send", ok, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_idle", db_rb_idle, 1);
      chk("rstmid_ctrl", {db_rb_req, db_rb_we, db_rb_done, db_rb_err, db_valid, last, db_ready}, 0);
      chk("rstmid_data", {db_rb_addr, db_rb_data, db_length, data_burst_out}, 0);
      chk("rstmid_no_done", done_cnt, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      burst_ready = 1'b1;
      clear_obs();
      start_xfer(1'b1, 9'h100, 8'd2, 8'd1);
      wait_done("rstnew");
      chk("rstnew_done_cnt", done_cnt, 1);
      chk("rstnew_nbeats", obq.size(), 2);
      if (obq.size() == 2) begin
        chk("rstnew_b0_addr", obq[0].a, 9'h100);
        chk("rstnew_b0_data", obq[0].d, 8'h5A);
        chk("rstnew_b0_last", obq[0].l, 1);
        chk("rstnew_b1_addr", obq[1].a, 9'h101);
        chk("rstnew_b1_data", obq[1].d, 8'h5B);
        chk("rstnew_b1_last", obq[1].l, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/burst_xfer_engine.md
# burst_xfer_engine

Parametrised successor to the data burst controller. It moves a programmed number of beats between the register bank and the burst interface. Write mode reads register-bank words and streams them out as bursts; read mode accepts incoming bursts and writes them into the register bank. Data, address and length widths are parameters. Both directions use full valid/ready back-pressure, a programmable base address and last-beat framing per burst.

## Interface
- DATA_W, 8, beat and register-bank data width
- ADDR_W, 9, register-bank address width
- LEN_W, 8, width of length and burst-size fields
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- rb_db_start  in  1  start request, sampled only in IDLE
- rb_db_rw  in  1  1 = write (RB -> burst out), 0 = read (burst in -> RB); latched at start
- rb_db_length  in  LEN_W  total beats; latched at start
- rb_db_max_burst_size  in  LEN_W  beats per burst, 0 treated as 1; latched at start
- rb_db_base_addr  in  ADDR_W  first register-bank address; latched at start
- rb_db_ack  in  1  register-bank access complete
- rb_db_data  in  DATA_W  register-bank read data, valid with rb_db_ack
- db_rb_req  out  1  register-bank access request, held until ack
- db_rb_we  out  1  1 = write access (read mode), 0 = read access
- db_rb_addr  out  ADDR_W  access address
- db_rb_data  out  DATA_W  write data to register bank
- db_rb_idle  out  1  high in IDLE
- db_rb_done  out  1  one-cycle pulse when a transaction ends
- db_rb_err  out  1  sticky framing error (see Configuration)
- db_length  out  LEN_W  latched transaction length
- db_valid / data_burst_out / last  out  1 / DATA_W / 1  outgoing beat, data and burst-end marker
- burst_ready  in  1  sink accepts outgoing beat
- burst_valid / data_burst_in / burst_last  in  1 / DATA_W / 1  incoming beat
- db_ready  out  1  engine accepts incoming beat

## Operation
- FSM states: IDLE, LOAD, WR_REQ, WR_SEND, RD_RECV, RD_STORE, DONE.
- All outputs are registered or decoded from the state register. There are no combinational input-to-output paths.
- IDLE: rb_db_start = 1 -> LOAD.
- LOAD: latch the parameters and clear db_rb_err. Load beat_rem = length, burst_rem = max_burst (0 -> 1) and addr = base. Next state:
  - length == 0 -> DONE;
  - rw = 1 -> WR_REQ;
  - rw = 0 -> RD_RECV.
- WR_REQ: db_rb_req = 1, db_rb_we = 0. On ack, capture rb_db_data into data_burst_out and go to WR_SEND.
- WR_SEND: db_valid = 1 and data is held stable until burst_ready. last = (beat_rem == 1) or (burst_rem == 1). On accept:
  - beat_rem decrements and addr increments;
  - burst_rem decrements, or reloads when it was 1;
  - next state is DONE if beat_rem was 1, else WR_REQ.
- RD_RECV: db_ready = 1. On burst_valid, capture data_burst_in into db_rb_data and go to RD_STORE.
- RD_STORE: db_rb_req = 1, db_rb_we = 1. On ack, counters update as in WR_SEND; next state is DONE or RD_RECV.
- DONE: db_rb_done = 1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^ADDR_W: base + length may wrap past the top of the address space, and 0 follows the top address.
- rb_db_start outside IDLE is ignored. Changes to the configuration inputs mid-transaction have no effect.
- Reset at any time aborts the transaction. There is no partial done pulse.

## Timing
- Reset values:
  - state IDLE;
  - db_rb_idle = 1;
  - all other 1-bit outputs 0;
  - all data, address and length outputs 0.
- Start sampled at edge N -> LOAD during cycle N+1 -> db_rb_idle low and first db_rb_req or db_ready from cycle N+2.
- Write beat: ack at edge E -> db_valid high from E+1. Best case is 2 cycles per beat with zero-wait ack and ready.
- Read beat: burst_valid at edge E -> db_rb_req from E+1. Best case is 2 cycles per beat.
- The last accepted beat at edge E gives db_rb_done during cycle E+1 and db_rb_idle high from E+2.
- Length 0: db_rb_done during cycle N+2, with no req and no beats.

## Configuration
- BURST_LAST_CHECK_EN defined:
  - in read mode, each accepted beat compares burst_last with the expected last (beat_rem == 1 or burst_rem == 1);
  - a mismatch sets db_rb_err, which stays set until the next LOAD;
  - the transfer continues regardless.
- Not defined: burst_last is ignored and db_rb_err is tied to 0.

## Test plan
- Write, base = 0x010, length = 5, max_burst = 2, ready and ack always 1 -> 5 beats, addresses 0x010..0x014, last on beats 2, 4 and 5, one done pulse.
- Read, base = 0x1FE, length = 4, max_burst = 4, ADDR_W = 9 -> RB writes to 0x1FE, 0x1FF, 0x000, 0x001 with incoming data in order.
- Write with burst_ready low for 3 cycles on beat 2 -> db_valid, data_burst_out and last held stable, no beat lost or duplicated.
- Length 0 with max_burst 0 -> done two cycles after start, no db_rb_req, no db_valid.
- Read, length = 4, max_burst = 2, burst_last high only on beat 4 (expected on beat 2) -> db_rb_err = 1 with the macro defined, 0 without. All 4 words written in both cases.
- rst_n low during WR_SEND -> all outputs return to reset values, db_rb_idle = 1. A new start then transfers from the new base correctly.
